// File: rtl/keypad_scanner.sv
// Row/column keypad scanner: frame-based debounce, key-code FIFO and interrupt pulse.
// Optional auto-repeat of the held key is built when KEYPAD_TYPEMATIC_EN is defined.
module keypad_scanner #(
   parameter int ROWS         = 4,
   parameter int COLS         = 3,
   parameter int SCAN_DIV     = 8,
   parameter int DEBOUNCE     = 3,
   parameter int FIFO_DEPTH   = 4,
   parameter int REPEAT_DELAY = 16,
   parameter int REPEAT_RATE  = 4
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic [ROWS-1:0] ROW_IN,
   input  logic            KEY_ACK,
   output logic [COLS-1:0] COL_DRV,
   output logic [7:0]      KEY_CODE,
   output logic            KEY_VALID,
   output logic            interrupt,
   output logic            OVERFLOW
);
   localparam int DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int CNT_MAX = (DEBOUNCE > RPT_MAX) ? DEBOUNCE : RPT_MAX;
   // One width serves both the debounce and the frame-repeat counters.
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [1:0] RELEASED     = 2'd0;
   localparam logic [1:0] PRESS_PEND   = 2'd1;
   localparam logic [1:0] HELD         = 2'd2;
   localparam logic [1:0] RELEASE_PEND = 2'd3;

   logic [ROWS-1:0]      row_s1, row_s2;
   logic [DIV_W-1:0]     div;
   logic [COL_W-1:0]     col_idx;
   logic [ROWS*COLS-1:0] frame, frame_nxt;
   logic                 sample, frame_end;
   logic                 cand_vld;
   logic [5:0]           cand_code;

   assign sample    = (div == DIV_W'(SCAN_DIV - 1));
   assign frame_end = sample && (col_idx == COL_W'(COLS - 1));

   // Frame bit index equals the key code (row*COLS+col); the column being sampled is merged in.
   always_comb begin
      frame_nxt = frame;
      if (sample)
         for (int c = 0; c < COLS; c++)
            if (col_idx == COL_W'(c))
               for (int r = 0; r < ROWS; r++)
                  frame_nxt[r*COLS+c] = row_s2[r];
   end

   always_comb begin
      cand_vld  = 1'b0;
      cand_code = '0;
      for (int i = ROWS*COLS-1; i >= 0; i--)
         if (frame_nxt[i]) begin
            cand_vld  = 1'b1;
            cand_code = 6'(i);
         end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         row_s1  <= '0;
         row_s2  <= '0;
         div     <= '0;
         col_idx <= '0;
         COL_DRV <= COLS'(1);
         frame   <= '0;
      end else begin
         row_s1 <= ROW_IN;
         row_s2 <= row_s1;
         frame  <= frame_nxt;
         if (sample) begin
            div     <= '0;
            col_idx <= (col_idx == COL_W'(COLS - 1)) ? '0 : col_idx + COL_W'(1);
            COL_DRV <= (COL_DRV << 1) | (COL_DRV >> (COLS - 1));
         end else begin
            div <= div + DIV_W'(1);
         end
      end
   end

   logic [1:0]       state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [5:0]       held_code, code_n;
   logic             same, fsm_push, rep_push, push;

   assign same = cand_vld && (cand_code == held_code);

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      code_n   = held_code;
      fsm_push = 1'b0;
      if (frame_end) begin
         case (state)
            RELEASED: if (cand_vld) begin
               code_n = cand_code;
               cnt_n  = CNT_W'(1);
               if (DEBOUNCE == 1) begin
                  state_n  = HELD;
                  fsm_push = 1'b1;
               end else begin
                  state_n = PRESS_PEND;
               end
            end
            PRESS_PEND: if (same) begin
               cnt_n = cnt + CNT_W'(1);
               if (cnt_n == CNT_W'(DEBOUNCE)) begin
                  state_n  = HELD;
                  fsm_push = 1'b1;
               end
            end else begin
               state_n = RELEASED;
            end
            HELD: if (!same) begin
               cnt_n   = CNT_W'(1);
               state_n = (DEBOUNCE == 1) ? RELEASED : RELEASE_PEND;
            end
            default: if (same) begin
               state_n = HELD;
            end else begin
               cnt_n = cnt + CNT_W'(1);
               if (cnt_n == CNT_W'(DEBOUNCE))
                  state_n = RELEASED;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= RELEASED;
         cnt       <= '0;
         held_code <= '0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         held_code <= code_n;
      end
   end

`ifdef KEYPAD_TYPEMATIC_EN
   logic [CNT_W-1:0] rep_cnt, rep_cnt_n;
   logic             rep_armed, rep_armed_n;

   // Counts frames spent continuously in HELD; first repeat after the delay, then at the rate.
   always_comb begin
      rep_cnt_n   = rep_cnt;
      rep_armed_n = rep_armed;
      rep_push    = 1'b0;
      if (state != HELD || state_n != HELD) begin
         rep_cnt_n   = '0;
         rep_armed_n = 1'b0;
      end else if (frame_end) begin
         rep_cnt_n = rep_cnt + CNT_W'(1);
         if (rep_cnt_n == (rep_armed ? CNT_W'(REPEAT_RATE) : CNT_W'(REPEAT_DELAY))) begin
            rep_push    = 1'b1;
            rep_cnt_n   = '0;
            rep_armed_n = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rep_cnt   <= '0;
         rep_armed <= 1'b0;
      end else begin
         rep_cnt   <= rep_cnt_n;
         rep_armed <= rep_armed_n;
      end
   end
`else
   assign rep_push = 1'b0;
`endif

   assign push = fsm_push | rep_push;

   logic [5:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_n;
   logic [PTR_W:0]   count, count_n, remain;
   logic [5:0]       head_n;
   logic             pop, full, do_push, drop;

   assign pop     = KEY_ACK && KEY_VALID;
   assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
   assign do_push = push && (!full || pop);
   assign drop    = push && full && !pop;

   // Head is precomputed so KEY_CODE/KEY_VALID leave straight from flops.
   always_comb begin
      rd_ptr_n = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
      remain   = count - (PTR_W+1)'(pop);
      count_n  = remain + (PTR_W+1)'(do_push);
      if (count_n == '0)
         head_n = '0;
      else if (remain == '0)
         head_n = code_n;
      else
         head_n = mem[rd_ptr_n];
   end

   always_ff @(posedge CLK) begin
      if (do_push)
         mem[wr_ptr] <= code_n;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         KEY_CODE  <= '0;
         KEY_VALID <= 1'b0;
         interrupt <= 1'b0;
         OVERFLOW  <= 1'b0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         rd_ptr    <= rd_ptr_n;
         count     <= count_n;
         KEY_CODE  <= {2'b00, head_n};
         KEY_VALID <= (count_n != '0);
         interrupt <= do_push;
         OVERFLOW  <= pop ? 1'b0 : (OVERFLOW | drop);
      end
   end
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed vector table, multi-cycle corner sequences and a
// randomized run against a frame-level reference model.
module tb_keypad_scanner;
   localparam int ROWS     = 4;
   localparam int COLS     = 3;
   localparam int SCAN_DIV = 8;
   localparam int DEBOUNCE = 3;
   localparam int FRAME    = COLS * SCAN_DIV;
   localparam int NKEYS    = ROWS * COLS;
   localparam logic [COLS-1:0] COL0 = 1;

   logic            CLK   = 1'b0;
   logic            RST_N = 1'b1;
   logic [ROWS-1:0] ROW_IN;
   logic            KEY_ACK = 1'b0;
   logic [COLS-1:0] COL_DRV;
   logic [7:0]      KEY_CODE;
   logic            KEY_VALID;
   logic            interrupt;
   logic            OVERFLOW;

   logic [NKEYS-1:0] keys = '0;
   int tests = 0;
   int fails = 0;
   int irq_cnt = 0;
   bit auto_ack = 1'b0;
   bit seen_valid = 1'b0;
   int got[$];
   int expq[$];

   keypad_scanner dut (
      .CLK(CLK), .RST_N(RST_N), .ROW_IN(ROW_IN), .KEY_ACK(KEY_ACK),
      .COL_DRV(COL_DRV), .KEY_CODE(KEY_CODE), .KEY_VALID(KEY_VALID),
      .interrupt(interrupt), .OVERFLOW(OVERFLOW)
   );

   always #5 CLK = ~CLK;

   // Keypad matrix: a row reads 1 when a closed key sits on the driven column.
   always_comb begin
      ROW_IN = '0;
      for (int r = 0; r < ROWS; r++)
         ROW_IN[r] = |(keys[r*COLS +: COLS] & COL_DRV);
   end

   always @(negedge CLK) if (interrupt) irq_cnt <= irq_cnt + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge CLK);
         if (KEY_VALID) seen_valid = 1'b1;
         if (auto_ack) begin
            if (KEY_VALID && !KEY_ACK) begin
               got.push_back(int'(KEY_CODE));
               KEY_ACK = 1'b1;
            end else begin
               KEY_ACK = 1'b0;
            end
         end
      end
   endtask

   task automatic align();
      logic [COLS-1:0] prev;
      bit ok;
      prev = COL_DRV;
      ok = 1'b0;
      for (int i = 0; i < 2*FRAME && !ok; i++) begin
         tick(1);
         if (COL_DRV == COL0 && prev != COL0) ok = 1'b1;
         prev = COL_DRV;
      end
      if (!ok) begin
         tests++;
         fails++;
         $display("FAIL align: no frame start seen, COL_DRV=%0d", COL_DRV);
      end
   endtask

   task automatic hold(input logic [NKEYS-1:0] m, input int nframes);
      keys = m;
      tick(nframes * FRAME);
   endtask

   task automatic ack_once();
      KEY_ACK = 1'b1;
      tick(1);
      KEY_ACK = 1'b0;
   endtask

   function automatic logic [NKEYS-1:0] onehot(input int k);
      logic [NKEYS-1:0] m;
      m = '0;
      m[k] = 1'b1;
      return m;
   endfunction

   function automatic int lowest(input logic [NKEYS-1:0] m);
      for (int i = 0; i < NKEYS; i++)
         if (m[i]) return i;
      return -1;
   endfunction

   typedef struct {
      logic [NKEYS-1:0] mask;
      int               code;
   } vec_t;

   vec_t vt[6];

   initial begin
      int v0, lat, k, g, code;
      bit held, force_same;
      logic [NKEYS-1:0] mask;

      vt[0] = '{12'h001, 0};
      vt[1] = '{12'h800, 11};
      vt[2] = '{12'h010, 4};
      vt[3] = '{12'h220, 5};
      vt[4] = '{12'h408, 3};
      vt[5] = '{12'h801, 0};

      #2 RST_N = 1'b0;
      repeat (3) @(negedge CLK);
      check("rst_col", 32'(COL_DRV), 32'(1));
      check("rst_valid", 32'(KEY_VALID), 32'(0));
      check("rst_code", 32'(KEY_CODE), 32'(0));
      check("rst_irq", 32'(interrupt), 32'(0));
      check("rst_ovf", 32'(OVERFLOW), 32'(0));
      RST_N = 1'b1;

      seen_valid = 1'b0;
      v0 = irq_cnt;
      for (int n = 1; n <= 48; n++) begin
         tick(1);
         check("col_seq", 32'(COL_DRV), 32'(1 << ((n / SCAN_DIV) % COLS)));
      end
      tick(152);
      check("idle_valid", 32'(seen_valid), 32'(0));
      check("idle_irq", 32'(irq_cnt - v0), 32'(0));

      // Key 7 (row 2, column 1) held for 6 frames.
      align();
      v0 = irq_cnt;
      keys = onehot(7);
      lat = -1;
      for (int i = 1; i <= 6*FRAME; i++) begin
         tick(1);
         if (lat < 0 && KEY_VALID) lat = i;
      end
      check("press7_latency_ok", 32'(lat > 0 && lat <= 4*FRAME+3), 32'(1));
      check("press7_code", 32'(KEY_CODE), 32'(7));
      check("press7_valid", 32'(KEY_VALID), 32'(1));
      check("press7_irq", 32'(irq_cnt - v0), 32'(1));
      keys = '0;
      ack_once();
      check("ack_valid", 32'(KEY_VALID), 32'(0));
      check("ack_code", 32'(KEY_CODE), 32'(0));
      tick(5*FRAME);

      for (int i = 0; i < 6; i++) begin
         align();
         v0 = irq_cnt;
         hold(vt[i].mask, 4);
         hold('0, 4);
         check("vec_valid", 32'(KEY_VALID), 32'(1));
         check("vec_code", 32'(KEY_CODE), 32'(vt[i].code));
         check("vec_irq", 32'(irq_cnt - v0), 32'(1));
         ack_once();
         check("vec_pop", 32'(KEY_VALID), 32'(0));
      end

      // Bounce: two frames on, one off, never reaches the debounce count.
      align();
      v0 = irq_cnt;
      seen_valid = 1'b0;
      repeat (5) begin
         hold(onehot(7), 2);
         hold('0, 1);
      end
      hold('0, 4);
      check("bounce_valid", 32'(seen_valid), 32'(0));
      check("bounce_irq", 32'(irq_cnt - v0), 32'(0));

      align();
      v0 = irq_cnt;
      for (int c = 1; c <= 5; c++) begin
         hold(onehot(c), 4);
         hold('0, 4);
      end
      check("ovf_valid", 32'(KEY_VALID), 32'(1));
      check("ovf_flag", 32'(OVERFLOW), 32'(1));
      check("ovf_irq", 32'(irq_cnt - v0), 32'(4));
      for (int c = 1; c <= 4; c++) begin
         check("ovf_pop_code", 32'(KEY_CODE), 32'(c));
         ack_once();
         if (c == 1) check("ovf_clear", 32'(OVERFLOW), 32'(0));
      end
      check("ovf_drained", 32'(KEY_VALID), 32'(0));

      // Auto-repeat (or a single push) while key 0 stays held for 40 frames.
      align();
      v0 = irq_cnt;
      hold(onehot(0), 40);
`ifdef KEYPAD_TYPEMATIC_EN
      check("rep_irq", 32'(irq_cnt - v0), 32'(4));
      check("rep_ovf", 32'(OVERFLOW), 32'(1));
`else
      check("single_irq", 32'(irq_cnt - v0), 32'(1));
      check("single_ovf", 32'(OVERFLOW), 32'(0));
`endif
      check("hold_code", 32'(KEY_CODE), 32'(0));
      keys = '0;
      for (int i = 0; i < 8 && KEY_VALID; i++) ack_once();
      tick(5*FRAME);

      // Keys 5 and 9 together, then reset while still held.
      align();
      v0 = irq_cnt;
      hold(12'h220, 5);
      check("multi_code", 32'(KEY_CODE), 32'(5));
      check("multi_irq", 32'(irq_cnt - v0), 32'(1));
      #2 RST_N = 1'b0;
      #1;
      check("midrst_col", 32'(COL_DRV), 32'(1));
      check("midrst_valid", 32'(KEY_VALID), 32'(0));
      check("midrst_code", 32'(KEY_CODE), 32'(0));
      check("midrst_irq", 32'(interrupt), 32'(0));
      check("midrst_ovf", 32'(OVERFLOW), 32'(0));
      keys = '0;
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      v0 = irq_cnt;
      seen_valid = 1'b0;
      tick(6*FRAME);
      check("stale_valid", 32'(seen_valid), 32'(0));
      check("stale_irq", 32'(irq_cnt - v0), 32'(0));

      // Randomized segments: key set for k frames, released for g frames.
      got.delete();
      expq.delete();
      held = 1'b0;
      force_same = 1'b0;
      mask = '0;
      auto_ack = 1'b1;
      align();
      v0 = irq_cnt;
      for (int s = 0; s < 30; s++) begin
         if (!force_same) begin
            mask = onehot($urandom_range(0, NKEYS-1));
            if ($urandom_range(0, 1) == 1) mask = mask | onehot($urandom_range(0, NKEYS-1));
         end
         k = $urandom_range(1, 5);
         g = $urandom_range(1, 5);
         code = lowest(mask);
         hold(mask, k);
         if (!held && k >= DEBOUNCE) begin
            expq.push_back(code);
            held = 1'b1;
         end
         hold('0, g);
         if (held && g >= DEBOUNCE) held = 1'b0;
         force_same = held;
      end
      hold('0, 4);
      tick(10);
      auto_ack = 1'b0;
      KEY_ACK = 1'b0;
      check("rnd_count", 32'(got.size()), 32'(expq.size()));
      for (int i = 0; i < expq.size() && i < got.size(); i++)
         check("rnd_code", 32'(got[i]), 32'(expq[i]));
      check("rnd_irq", 32'(irq_cnt - v0), 32'(expq.size()));
      check("rnd_ovf", 32'(OVERFLOW), 32'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
